mips_muldiv_unit: RTL and testbench
===================================

// Module: mips_muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core.
//   Sits beside the single-cycle ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//   Uses an iterative one-bit-per-cycle shift-add multiplier and a restoring divider.
//   Control holds the pipeline while busy is high and reads HI/LO directly for MFHI/MFLO.
// PARAMETERS
//   WIDTH   32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset
//   start    in   1      request strobe; sampled at posedge clk
//   op       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x is a no-op
//   src_a    in   WIDTH  rs operand: multiplicand/dividend, or MTHI/MTLO data
//   src_b    in   WIDTH  rt operand: multiplier/divisor
//   busy     out  1      high while an arithmetic op is iterating
//   done     out  1      one-cycle pulse; HI/LO hold the new result in the same cycle
//   hi       out  WIDTH  HI register (product upper half / remainder)
//   lo       out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//   Reset (async, any time, including mid-operation)
//     - state=IDLE, busy=0, done=0, hi=0, lo=0; any in-flight op is discarded.
//   States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
//   Accept: start=1 && state!=RUN at a posedge. In RUN, start is ignored for all ops.
//   MULT/MULTU/DIV/DIVU on accept
//     - Latch operands; signed ops latch magnitudes and record result/remainder signs.
//     - Load count=WIDTH-1; go to RUN.
//   RUN
//     - Each edge performs one iteration and decrements count.
//     - On the edge with count==0: do the final iteration, apply sign correction,
//       write hi/lo, then go to DONE.
//     - RUN lasts exactly WIDTH cycles.
//   Latency
//     - start sampled at end of cycle 0; busy=1 in cycles 1..WIDTH.
//     - done=1 with valid hi/lo in cycle WIDTH+1.
//   DONE
//     - Lasts one cycle, then IDLE. A start in DONE is accepted (back-to-back ops).
//   MTHI/MTLO
//     - On accept, hi (or lo) <= src_a at that edge. Single cycle.
//     - No busy, no done; state stays/returns to IDLE.
//   Arithmetic
//     - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed/unsigned.
//     - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder,
//       taking the sign of the dividend.
//     - DIV of most-negative by -1: lo = most-negative (wrap), hi = 0.
//   Divide by zero (signed or unsigned)
//     - lo = all ones, hi = src_a.
//     - Still takes the full WIDTH-cycle latency, for deterministic timing.
//   hi/lo otherwise hold their values; in-progress partials stay internal until the final edge.
// TESTING
//   1. MULT a=0xFFFFFFFD (-3), b=5 -> busy cycles 1..32; done cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//   2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU a=7, b=2 -> lo=3, hi=1.
//   4. DIVU a=0x1234, b=0 -> done at cycle 33; hi=0x00001234, lo=0xFFFFFFFF.
//      DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
//   5. During RUN, apply start with MTHI a=0xDEAD and with MULT -> both ignored; hi/lo reflect only the first op.
//      MTLO 0x55 in IDLE -> lo=0x55 next cycle; done stays 0.
//   6. Assert reset in cycle 10 of a DIV -> busy=0, done=0, hi=lo=0 immediately.
//      A new MULT after reset completes normally with full latency.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// One iteration per clock: shift-add multiply, restoring divide, sign fix-up on the last edge.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Handshake: a request is taken when start=1 at a posedge while busy=0;
    // the result is valid in hi/lo during the single cycle where done=1.
    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic [WIDTH-1:0] work_hi_q, work_lo_q, operand_q, a_raw_q;
    logic            is_div_q, neg_lo_q, neg_hi_q, div0_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic            busy_q, done_q;

    // Operand preparation at accept time
    logic             op_signed, op_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_signed = ~op[0];
        op_div    = op[1];
        a_neg     = op_signed & src_a[WIDTH-1];
        b_neg     = op_signed & src_b[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
    end

    // One multiply step: conditional add of the multiplicand, then shift the
    // {carry, accumulator, multiplier} chain right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

    always_comb begin
        mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end

    // One restoring-divide step: shift the next dividend bit into the
    // remainder and keep the trial difference if it did not go negative.
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] div_rem_n, div_quo_n;

    always_comb begin
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, operand_q};
        if (!div_trial[WIDTH]) begin
            div_rem_n = div_trial[WIDTH-1:0];
            div_quo_n = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_n = div_shift[WIDTH-1:0];
            div_quo_n = {work_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        step_hi  = is_div_q ? div_rem_n : mul_hi_n;
        step_lo  = is_div_q ? div_quo_n : mul_lo_n;
        prod     = {mul_hi_n, mul_lo_n};
        prod_fix = neg_lo_q ? -prod : prod;
        quo_fix  = neg_lo_q ? -div_quo_n : div_quo_n;
        rem_fix  = neg_hi_q ? -div_rem_n : div_rem_n;
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero reports the raw dividend, ignoring sign handling.
            if (div0_q) begin
                fin_hi = a_raw_q;
                fin_lo = '1;
            end else begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            operand_q <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    work_hi_q <= step_hi;
                    work_lo_q <= step_lo;
                    count_q   <= count_q - 1'b1;
                    if (count_q == '0) begin
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                work_hi_q <= '0;
                                work_lo_q <= op_div ? a_mag : b_mag;
                                operand_q <= op_div ? b_mag : a_mag;
                                a_raw_q   <= src_a;
                                is_div_q  <= op_div;
                                neg_lo_q  <= a_neg ^ b_neg;
                                neg_hi_q  <= a_neg;
                                div0_q    <= (src_b == '0);
                                count_q   <= CW'(WIDTH - 1);
                                state_q   <= S_RUN;
                                busy_q    <= 1'b1;
                            end
                            3'b100:  hi_q <= src_a;
                            3'b101:  lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: randomized and directed ops checked
// against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*W-1:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [W-1:0]   arch_hi = '0;
  logic [W-1:0]   arch_lo = '0;
  int             n_checks = 0;
  int             n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint       sa, sb, q, r;
    logic [63:0]  p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      3'd0: p = 64'(sa * sb);
      3'd1: p = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          qv = q;
          rv = r;
          p = {rv[31:0], qv[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // monitor: pops and compares on every done pulse
  logic [63:0] mon_e;
  int          mon_c;
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: got done=1, expected no result pending (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("result_hi_lo", {hi, lo}, mon_e);
        check("done_cycle", 64'(cyc), 64'(mon_c));
        arch_hi = mon_e[63:32];
        arch_lo = mon_e[31:0];
      end
    end
  end

  // driver: call at a negedge; returns one negedge later with start dropped
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_accept, output int t);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    t = cyc;
    if (expect_accept && !o[2]) begin
      exp_q.push_back(model(o, a, b));
      exp_cyc_q.push_back(t + W + 1);
    end
    if (expect_accept && o == 3'b100) arch_hi = a;
    if (expect_accept && o == 3'b101) arch_lo = a;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [63:0] first;
    logic [W-1:0] rv;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    reset = 1'b0;

    // MULT -3 * 5 with busy window and done timing
    @(negedge clk);
    issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1, t);
    for (int i = 1; i <= W; i++) begin
      check($sformatf("mult_busy_c%0d", i), busy, 1);
      if (i < W) @(negedge clk);
    end
    @(negedge clk);
    check("mult_busy_end", busy, 0);
    check("mult_done_pulse", done, 1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // MULTU all ones
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, t);
    wait_idle();
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // DIV -7/2 then DIVU 7/2 issued in the DONE cycle
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, t);
    repeat (W) @(negedge clk);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'b011, 32'd7, 32'd2, 1, t);
    wait_idle();
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // divide by zero and overflow
    @(negedge clk);
    issue(3'b011, 32'h0000_1234, 32'd0, 1, t);
    wait_idle();
    check("divu0_hi", hi, 32'h0000_1234);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, t);
    wait_idle();
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);

    // starts during RUN are ignored
    @(negedge clk);
    first = model(3'b000, 32'h1234_5678, 32'h0000_9ABC);
    issue(3'b000, 32'h1234_5678, 32'h0000_9ABC, 1, t);
    repeat (3) @(negedge clk);
    issue(3'b100, 32'h0000_DEAD, 32'd0, 0, t);
    check("run_mthi_ignored", hi, arch_hi);
    repeat (4) @(negedge clk);
    issue(3'b000, $urandom, $urandom, 0, t);
    check("run_mult_ignored_busy", busy, 1);
    check("run_lo_held", lo, arch_lo);
    wait_idle();
    check("run_first_result", {hi, lo}, first);
    @(negedge clk);

    // MTLO in IDLE
    issue(3'b101, 32'h0000_0055, 32'd0, 1, t);
    check("mtlo_lo", lo, 32'h0000_0055);
    check("mtlo_hi_kept", hi, first[63:32]);
    check("mtlo_no_done", done, 0);
    check("mtlo_no_busy", busy, 0);
    @(negedge clk);
    issue(3'b110, 32'h1111_1111, 32'h2222_2222, 1, t);
    check("noop_hi", hi, arch_hi);
    check("noop_lo", lo, arch_lo);
    check("noop_busy", busy, 0);

    // reset in cycle 10 of a DIV
    @(negedge clk);
    issue(3'b010, 32'h7654_3210, 32'h0000_0123, 1, t);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    exp_q.delete();
    exp_cyc_q.delete();
    arch_hi = '0;
    arch_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'b000, 32'hFFFF_0001, 32'h0001_FFFF, 1, t);
    wait_idle();
    @(negedge clk);

    // randomized mix with back-to-back issue and MTHI/MTLO in idle
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1, t);
      if ($urandom_range(0, 1) == 1) begin
        repeat (W) @(negedge clk);
      end else begin
        wait_idle();
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          rv = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            issue(3'b100, rv, $urandom, 1, t);
            check("rand_mthi", hi, rv);
          end else begin
            issue(3'b101, rv, $urandom, 1, t);
            check("rand_mtlo", lo, rv);
          end
          check("rand_mt_no_busy", busy, 0);
        end
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("final_hi", hi, arch_hi);
    check("final_lo", lo, arch_lo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
